// File: rtl/conv_kernel_mac.sv
// conv_kernel_mac: 3x3 window MAC against a registered signed coefficient ROM, one result per window.
// Build option CONV_SAT_EN: clamp the normalised result to the unsigned pixel range.
module conv_kernel_mac #(
  parameter int PIX_W      = 8,
  parameter int COEF_W     = 5,
  parameter int NORM_SHIFT = 0,
  parameter int ACC_W      = 18
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 win_valid_i,
  output logic                 win_ready_o,
  input  logic [9*PIX_W-1:0]   win_data_i,
  output logic [3:0]           ker_addr_o,
  input  logic [COEF_W-1:0]    ker_dout_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [ACC_W-1:0]     res_data_o
);

  localparam int PROD_W = PIX_W + COEF_W + 1;
  localparam logic signed [ACC_W-1:0] PIX_MAX = {{(ACC_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [3:0]                addr_q, addr_d;
  logic [9*PIX_W-1:0]        win_q, win_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      res_valid_q, res_valid_d;
  logic [ACC_W-1:0]          res_data_q, res_data_d;

  logic [3:0]                tapIdx;
  logic [PIX_W-1:0]          tapPix;
  logic signed [PROD_W-1:0]  pixS, coefS, prod;
  logic signed [ACC_W-1:0]   prodExt, sum, shifted, result;

  // cnt_q counts edges since accept; the ROM word now on ker_dout_i belongs to tap cnt_q-1.
  assign tapIdx = cnt_q - 4'd1;

  always_comb begin
    tapPix = '0;
    for (int k = 0; k < 9; k++) begin
      if (tapIdx == 4'(k)) tapPix = win_q[PIX_W*k +: PIX_W];
    end
  end

  assign pixS    = {{(COEF_W+1){1'b0}}, tapPix};
  assign coefS   = {{(PIX_W+1){ker_dout_i[COEF_W-1]}}, ker_dout_i};
  assign prod    = pixS * coefS;
  assign prodExt = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign sum     = acc_q + prodExt;
  assign shifted = sum >>> NORM_SHIFT;

  always_comb begin
    result = shifted;
`ifdef CONV_SAT_EN
    if (shifted[ACC_W-1]) begin
      result = '0;
    end else if (shifted > PIX_MAX) begin
      result = PIX_MAX;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    win_d       = win_q;
    acc_d       = acc_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid_i) begin
          state_d = RUN;
          win_d   = win_data_i;
          acc_d   = '0;
          addr_d  = 4'd0;
          cnt_d   = 4'd0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q < 4'd8) addr_d = cnt_q + 4'd1;
        if ((cnt_q >= 4'd1) && (cnt_q <= 4'd8)) acc_d = sum;
        // Tenth edge after accept folds in tap 8 directly into the result register.
        if (cnt_q == 4'd9) begin
          res_data_d  = result;
          res_valid_d = 1'b1;
          addr_d      = 4'd0;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 4'd0;
      win_q       <= '0;
      acc_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      win_q       <= win_d;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign win_ready_o = (state_q == IDLE);
  assign ker_addr_o  = addr_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;

endmodule

// File: tb/tb_conv_kernel_mac.sv
// tb_conv_kernel_mac: scoreboard bench with a registered coefficient ROM model and an arithmetic reference.
// Honours CONV_SAT_EN in the reference so either build can be checked.
module tb_conv_kernel_mac;

  localparam int NS = 5;

  logic        clk;
  logic        rstN;
  logic        winValid;
  logic        winReady;
  logic [71:0] winData;
  logic [3:0]  kerAddr;
  logic [4:0]  kerDout;
  logic        resValid;
  logic        resReady;
  logic [17:0] resData;

  logic [44:0] curCoefs;
  logic        keepValid;
  int          tests;
  int          fails;
  int          cyc;

  typedef struct {
    logic [17:0] data;
    int          acceptCyc;
  } expT;
  expT sbQ[$];

  conv_kernel_mac #(.PIX_W(8), .COEF_W(5), .NORM_SHIFT(NS), .ACC_W(18)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .win_valid_i(winValid), .win_ready_o(winReady), .win_data_i(winData),
    .ker_addr_o(kerAddr), .ker_dout_i(kerDout),
    .res_valid_o(resValid), .res_ready_i(resReady), .res_data_o(resData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Coefficient ROM with one clock of read latency.
  initial begin
    kerDout = '0;
    forever begin
      @(posedge clk);
      kerDout <= curCoefs[5*kerAddr +: 5];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [17:0] refModel(input logic [71:0] pix, input logic [44:0] coefs);
    int sum;
    sum = 0;
    for (int k = 0; k < 9; k++) begin
      sum = sum + int'(pix[8*k +: 8]) * int'($signed(coefs[5*k +: 5]));
    end
    sum = sum >>> NS;
`ifdef CONV_SAT_EN
    if (sum < 0) sum = 0;
    else if (sum > 255) sum = 255;
`endif
    return 18'(sum);
  endfunction

  function automatic logic [44:0] packK(input int c0, input int c1, input int c2, input int c3,
                                        input int c4, input int c5, input int c6, input int c7,
                                        input int c8);
    int c[9];
    logic [44:0] r;
    c = '{c0, c1, c2, c3, c4, c5, c6, c7, c8};
    r = '0;
    for (int k = 0; k < 9; k++) r[5*k +: 5] = 5'(c[k]);
    return r;
  endfunction

  function automatic logic [71:0] fillPix(input logic [7:0] v);
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[8*k +: 8] = v;
    return r;
  endfunction

  // Monitor: pushes the expected result on each accept, pops on each result handshake.
  logic        prevValid;
  logic        hsPrev;
  logic [17:0] heldData;
  int          runStart;
  initial begin
    prevValid = 1'b0;
    hsPrev    = 1'b0;
    heldData  = '0;
    runStart  = -1;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        sbQ.delete();
        prevValid = 1'b0;
        hsPrev    = 1'b0;
        runStart  = -1;
      end else begin
        if (hsPrev) checkOutput("win_ready after handshake", 32'(winReady), 32'd1);
        hsPrev = 1'b0;
        if (runStart >= 0 && cyc >= runStart && cyc <= runStart + 8) begin
          checkOutput("ker_addr trace", 32'(kerAddr), 32'(cyc - runStart));
          checkOutput("win_ready low in run", 32'(winReady), 32'd0);
        end
        if (kerAddr > 4'd8) checkOutput("ker_addr range", 32'(kerAddr), 32'd8);
        if (resValid && !prevValid) begin
          if (sbQ.size() == 0) checkOutput("unexpected result", 32'(resValid), 32'd0);
          else checkOutput("latency", 32'(cyc - sbQ[0].acceptCyc), 32'd10);
        end
        if (resValid && prevValid) begin
          checkOutput("hold res_data", 32'(resData), 32'(heldData));
          checkOutput("hold win_ready", 32'(winReady), 32'd0);
          checkOutput("hold ker_addr", 32'(kerAddr), 32'd0);
        end
        heldData = resData;
        if (resValid && resReady && sbQ.size() > 0) begin
          expT e;
          e = sbQ.pop_front();
          checkOutput("result", 32'(resData), 32'(e.data));
          hsPrev = 1'b1;
        end
        if (winValid && winReady) begin
          expT n;
          n.data      = refModel(winData, curCoefs);
          n.acceptCyc = cyc + 1;
          sbQ.push_back(n);
          runStart = cyc + 1;
        end
        prevValid = resValid;
      end
    end
  end

  task automatic applyStimulus(input logic [71:0] pix, input logic [44:0] coefs, input int holdClks,
                               input bit earlyReady, input bit expectNow);
    int guard;
    curCoefs = coefs;
    winData  = pix;
    winValid = 1'b1;
    guard    = 0;
    while (!winReady && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!winReady) begin
      checkOutput("accept timeout", 32'(winReady), 32'd1);
      winValid = 1'b0;
      return;
    end
    if (expectNow) checkOutput("back-to-back accept wait", 32'(guard), 32'd0);
    @(posedge clk); #1;
    if (!keepValid) winValid = 1'b0;
    if (earlyReady) resReady = 1'b1;
    guard = 0;
    while (!resValid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!resValid) begin
      checkOutput("result timeout", 32'(resValid), 32'd1);
      resReady = 1'b0;
      return;
    end
    repeat (holdClks) begin
      @(posedge clk); #1;
    end
    resReady = 1'b1;
    @(posedge clk); #1;
    resReady = 1'b0;
  endtask

  logic [44:0] blurK, edgeK, sharpK, rndK;
  logic [71:0] pix;

  initial begin
    tests = 0; fails = 0;
    rstN = 1'b0; winValid = 1'b0; resReady = 1'b0; winData = '0; curCoefs = '0; keepValid = 1'b0;
    blurK  = packK(3, 3, 3, 3, 8, 3, 3, 3, 3);
    edgeK  = packK(0, 1, 0, 1, -4, 1, 0, 1, 0);
    sharpK = packK(0, -1, 0, -1, 5, -1, 0, -1, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset win_ready", 32'(winReady), 32'd1);
    checkOutput("reset ker_addr", 32'(kerAddr), 32'd0);
    checkOutput("reset res_valid", 32'(resValid), 32'd0);
    checkOutput("reset res_data", 32'(resData), 32'd0);
    rstN = 1'b1;
    @(posedge clk); #1;

    applyStimulus(fillPix(8'd100), blurK, 0, 1'b0, 1'b0);
    pix = '0; pix[32 +: 8] = 8'd255;
    applyStimulus(pix, edgeK, 0, 1'b0, 1'b0);
    applyStimulus(fillPix(8'd50), edgeK, 0, 1'b0, 1'b0);
    pix = '0; pix[32 +: 8] = 8'd200;
    pix[8 +: 8] = 8'd10; pix[24 +: 8] = 8'd10; pix[40 +: 8] = 8'd10; pix[56 +: 8] = 8'd10;
    applyStimulus(pix, sharpK, 0, 1'b0, 1'b0);
    applyStimulus(fillPix(8'd180), sharpK, 5, 1'b0, 1'b0);
    applyStimulus(fillPix(8'd90), blurK, 0, 1'b1, 1'b1);

    // Reset in the middle of a run, then a clean blur window.
    curCoefs = blurK; winData = fillPix(8'd77); winValid = 1'b1;
    @(posedge clk); #1;
    winValid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("mid-run reset win_ready", 32'(winReady), 32'd1);
    checkOutput("mid-run reset ker_addr", 32'(kerAddr), 32'd0);
    checkOutput("mid-run reset res_valid", 32'(resValid), 32'd0);
    checkOutput("mid-run reset res_data", 32'(resData), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    applyStimulus(fillPix(8'd100), blurK, 0, 1'b0, 1'b0);

    keepValid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 9; k++) pix[8*k +: 8] = 8'($urandom);
      applyStimulus(pix, edgeK, 0, 1'b0, w > 0);
    end
    keepValid = 1'b0;
    winValid  = 1'b0;

    for (int w = 0; w < 20; w++) begin
      bit early;
      for (int k = 0; k < 9; k++) begin
        pix[8*k +: 8]  = 8'($urandom);
        rndK[5*k +: 5] = 5'($urandom);
      end
      early = 1'($urandom_range(0, 1));
      applyStimulus(pix, rndK, early ? 0 : int'($urandom_range(0, 3)), early, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
